// File: rtl/reg_pipe_pkg.sv
// reg_pipe_pkg: shared defaults and sizing helper for the reg_pipe pipeline.
package reg_pipe_pkg;

   localparam int DEF_WIDTH     = 8;
   localparam int DEF_DEPTH     = 4;
   localparam int DEF_RESET_VAL = 0;

   function automatic int occ_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// reg_pipe_stage: one pipeline slot, a valid bit plus a data word.
// Reset beats clear, and clear beats load; clear drops valid only.
module reg_pipe_stage #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_clear,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_data  <= RESET_VAL;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= i_valid;
         r_data  <= i_data;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage valid/ready register pipeline with bubble collapsing.
// Define REG_PIPE_OCC_EN to build the occupancy counter; otherwise it is 0.
module reg_pipe
   import reg_pipe_pkg::*;
#(
   parameter int               WIDTH     = DEF_WIDTH,
   parameter int               DEPTH     = DEF_DEPTH,
   parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [occ_w(DEPTH)-1:0]    occupancy
);

   localparam int OW = occ_w(DEPTH);

   logic [DEPTH-1:0] w_v;
   logic [DEPTH-1:0] w_adv;
   logic [DEPTH-1:0] w_vin;
   logic [WIDTH-1:0] w_d    [DEPTH];
   logic [WIDTH-1:0] w_d_in [DEPTH];

   // A stage advances if empty or if the stage ahead of it advances.
   always_comb begin
      w_adv = '0;
      w_adv[DEPTH-1] = ~w_v[DEPTH-1] | out_ready;
      for (int k = DEPTH - 2; k >= 0; k--) begin
         w_adv[k] = ~w_v[k] | w_adv[k+1];
      end
   end

   assign in_ready = w_adv[0] & ~flush;

   always_comb begin
      w_vin     = '0;
      w_vin[0]  = in_valid & in_ready;
      w_d_in[0] = in_data;
      for (int k = 1; k < DEPTH; k++) begin
         w_vin[k]  = w_v[k-1];
         w_d_in[k] = w_d[k-1];
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      reg_pipe_stage #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_stage (
         .clk     (clk),
         .reset   (reset),
         .i_load  (w_adv[g]),
         .i_clear (flush),
         .i_valid (w_vin[g]),
         .i_data  (w_d_in[g]),
         .o_valid (w_v[g]),
         .o_data  (w_d[g])
      );
   end

   assign out_valid = w_v[DEPTH-1];
   assign out_data  = w_d[DEPTH-1];

`ifdef REG_PIPE_OCC_EN
   logic [DEPTH-1:0] w_vnext;
   logic [OW-1:0]    r_occ;

   assign w_vnext = (w_adv & w_vin) | (~w_adv & w_v);

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_occ <= '0;
      end else begin
         r_occ <= OW'($countones(w_vnext));
      end
   end

   assign occupancy = r_occ;
`else
   assign occupancy = '0;
`endif

endmodule

// File: doc/reg_pipe.md
REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data bits per word (>=1).
REQ-002 Parameter DEPTH, default 4, number of register stages (>=1).
REQ-003 Parameter RESET_VAL, default 0, WIDTH-bit value loaded into every data stage on reset.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge only.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 flush  input  1  synchronous clear of all stage valid bits.
REQ-007 in_valid  input  1  upstream word present.
REQ-008 in_ready  output  1  pipeline accepts a word this cycle.
REQ-009 in_data  input  WIDTH  upstream word.
REQ-010 out_valid  output  1  last stage holds a word.
REQ-011 out_ready  input  1  downstream accepts a word this cycle.
REQ-012 out_data  output  WIDTH  last-stage word.
REQ-013 occupancy  output  $clog2(DEPTH+1)  count of valid stages.

Function
REQ-014 Each stage k SHALL hold a valid bit v[k] and data d[k]; stage 0 faces input, stage DEPTH-1 drives out_valid/out_data directly from registers.
REQ-015 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-016 Stage k SHALL advance (load from k-1, or from input for k=0) when v[k]=0 or stage k is itself emptied this cycle (bubble collapsing).
REQ-017 Last stage is emptied when out_ready=1; in_ready SHALL equal (~v[0] | stage0_advances) & ~flush, combinationally.
REQ-018 Data SHALL not change in a stage that does not advance; in_ready SHALL not depend on in_valid.
REQ-019 Latency with out_ready held 1 and empty pipe: word accepted at cycle n appears with out_valid=1 at cycle n+DEPTH.
REQ-020 Throughput: one word per cycle sustained when out_ready=1; no words lost, duplicated or reordered.
REQ-021 Full pipe (all v=1) with out_ready=0: in_ready=0, all stages hold.
REQ-022 Full pipe with out_ready=1: in_ready=1, simultaneous accept and release, occupancy unchanged.
REQ-023 flush=1: next edge SHALL clear every v[k]; input word in that cycle is not accepted; out side handshake in that cycle still completes; data registers keep contents.
REQ-024 occupancy SHALL equal the number of set v[k], registered, updated in the same edge as v.

Reset
REQ-025 reset=1 at a rising edge SHALL clear all v[k], load RESET_VAL into all d[k], clear occupancy.
REQ-026 After reset: out_valid=0, out_data=RESET_VAL, in_ready=1 (flush=0), occupancy=0.
REQ-027 reset SHALL override flush and any handshake in the same cycle; words in flight are discarded.

Configuration
REQ-028 Macro REG_PIPE_OCC_EN defined: occupancy counter implemented per REQ-024.
REQ-029 Macro REG_PIPE_OCC_EN undefined: occupancy port present but tied to 0, no counter logic; all other behaviour identical.

Structure
REQ-030 Package reg_pipe_pkg SHALL hold default WIDTH/DEPTH/RESET_VAL constants and the occupancy-width function.
REQ-031 One sub-module reg_pipe_stage (valid bit + WIDTH data register, load enable, clear, sync reset) SHALL be instantiated DEPTH times in a generate loop.

Verification (WIDTH=8, DEPTH=4, REG_PIPE_OCC_EN defined unless stated)
REQ-032 Reset: reset=1 two cycles, release -> out_valid=0, out_data=8'h00, in_ready=1, occupancy=0.
REQ-033 Streaming: out_ready=1, push 8'h11,8'h22,8'h33 back-to-back from cycle 1 -> out 8'h11 at cycle 5, 8'h22 at 6, 8'h33 at 7; occupancy peaks at 3.
REQ-034 Backpressure: out_ready=0, push 6 words 8'hA0..8'hA5 -> first 4 accepted, in_ready=0, occupancy=4; raise out_ready -> outputs A0..A5 in order, no gaps beyond pipeline.
REQ-035 Full pass-through: pipe full, out_ready=1, in_valid=1 with 8'hB0 -> in_ready=1, occupancy stays 4 that cycle.
REQ-036 Flush: pipe holding 3 words, flush=1 one cycle with in_valid=1, in_data=8'hCC -> next cycle out_valid=0, occupancy=0, 8'hCC never appears at output.
REQ-037 Reset mid-stream and macro off: reset=1 with pipe full -> next cycle out_valid=0, out_data=8'h00; rebuild without REG_PIPE_OCC_EN, rerun REQ-033 -> same data, occupancy constant 0.
